issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//  Issue controller between the decode stage and the execution units. Tracks outstanding
//  register writes in a 64-entry scoreboard and holds decode on RAW/WAW hazards or a busy
//  unit. Drives decode's stall/cancel, issues one instruction per cycle to a one-hot unit,
//  and sequences pipeline flushes on branch redirect.
// PARAMETERS
//  NUM_UNITS  8   execution units, indexed by decode's 3-bit unit field
//  WB_PORTS   2   writeback ports that clear scoreboard bits each cycle
//  MAX_OUT    15  max in-flight instructions; the outstanding counter is 4 bits
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous reset, active-high
//  dec_valid    in   1          decode output registers hold a real instruction
//  dec_type     in   1          0=R-type, 1=I-type
//  dec_unit     in   3          target unit
//  dec_op       in   2          unit opcode
//  dec_r1_rn    in   6          first source read (0 = none)
//  dec_r2_rn    in   6          second source read (0 = none)
//  dec_rd_rn    in   6          primary destination
//  dec_rd2_rn   in   6          secondary destination
//  unit_ready   in   NUM_UNITS  unit can accept an instruction this cycle
//  wb_valid     in   WB_PORTS   writeback strobe per port
//  wb_rn        in   6*WB_PORTS register written by each port
//  flush_req    in   1          branch redirect: discard all younger work
//  stall        out  1          to decode: hold outputs
//  cancel       out  1          to decode: squash outputs
//  issue_valid  out  1          instruction issued this cycle
//  issue_unit   out  NUM_UNITS  one-hot unit select, qualified by issue_valid
//  busy_map     out  64         scoreboard contents (debug/verification)
// BEHAVIOUR
//  Reset: stall=0, cancel=0, issue_valid=0, issue_unit=0, busy_map=0, count=0, state=RUN.
//  Write set: rd written unless rd_rn==0, I-type unit 6 (stores), or I-type unit 7 with
//   op[1]==0 (BEQ/BEQAL). rd2 written only for R-type unit 2, and only when rd2_rn!=0.
//  Hazard: busy[r1] | busy[r2] | busy[rd] | busy[rd2], evaluated only for registers
//   that are used; r0 is never busy.
//  Issue is combinational in cycle t: dec_valid & ~hazard & unit_ready[unit] &
//   count<MAX_OUT & state==RUN. Issue sets the write-set bits at t+1 and increments count.
//  stall = dec_valid & ~issue (combinational), so decode holds in the same cycle.
//  Writeback: each wb_valid clears busy[wb_rn] at t+1 and decrements count by 1 per port.
//   Clears are not bypassed, so a dependent instruction issues one cycle after writeback.
//  Same-register set and clear in one cycle: the set wins (the new write is pending).
//  The count update is net: +issue - popcount(wb_valid). Underflow is an assertion error.
//  FSM (Moore for cancel):
//   RUN   -> FLUSH on flush_req. Issue is blocked in that same cycle.
//   FLUSH -> cancel=1 for exactly one cycle; busy_map is NOT cleared because in-flight
//            ops still write back; goes to DRAIN.
//   DRAIN -> no issue, stall=dec_valid; writebacks continue; goes to RUN when count==0.
//  flush_req while in FLUSH or DRAIN is absorbed; DRAIN restarts its wait with no extra cancel.
//  Reset asserted mid-drain returns to RUN with an empty scoreboard in the next cycle.
// STRUCTURE
//  sched_defs.vh: unit codes (UNIT_STORE=6, UNIT_BRANCH=7, UNIT_MULDIV=2), FSM state
//   encodings, and the write-set predicate macros. These are shared with decode and the
//   unit wrappers.
//  Sub-module sched_scoreboard: 64-bit busy vector with one set port (two regs) and
//   WB_PORTS clear ports, plus 4-read hazard lookup. The FSM and counter stay in the top.
// TESTING
//  1. Reset, then ADD r5<-r1,r2 with all units ready -> issue_valid=1, unit one-hot
//     8'h01, busy_map[5]=1 next cycle.
//  2. ADD r5; next instr reads r5 -> stall=1 until wb_valid[0], wb_rn=5; issues the
//     cycle after the clear.
//  3. Store reading r7, rd_rn=7 busy only via rs -> stall; store never sets busy[7].
//     BEQ sets no bits.
//  4. MUL R-type unit 2 with rd=3, rd2=4 -> busy bits 3 and 4 set; two simultaneous
//     wb ports clear both and count drops by 2.
//  5. Three ops in flight, flush_req -> cancel=1 for one cycle, no issue until 3
//     writebacks, then RUN.
//  6. Issue r9 write and wb r9 in the same cycle -> busy[9] stays 1; 15 in-flight ops
//     -> 16th stalls.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler: unit codes, FSM states and the
// destination write-set predicates also used by decode and the unit wrappers.
package issue_scheduler_pkg;

    localparam int NUM_UNITS = 8;
    localparam int WB_PORTS  = 2;
    localparam int NUM_REGS  = 64;
    localparam int RN_W      = 6;
    localparam int CNT_W     = 4;

    localparam logic [CNT_W-1:0] MAX_OUT = 4'd15;

    localparam logic [2:0] UNIT_MULDIV = 3'd2;
    localparam logic [2:0] UNIT_STORE  = 3'd6;
    localparam logic [2:0] UNIT_BRANCH = 3'd7;

    localparam logic TYPE_R = 1'b0;
    localparam logic TYPE_I = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // Stores and BEQ/BEQAL (op[1]==0) have no primary destination.
    function automatic logic writes_rd(input logic ty, input logic [2:0] unit,
                                       input logic [1:0] op, input logic [RN_W-1:0] rd);
        logic is_store;
        logic is_beq;
        is_store  = (ty == TYPE_I) && (unit == UNIT_STORE);
        is_beq    = (ty == TYPE_I) && (unit == UNIT_BRANCH) && !op[1];
        writes_rd = (rd != '0) && !is_store && !is_beq;
    endfunction

    // Only the R-type mul/div unit produces a second result.
    function automatic logic writes_rd2(input logic ty, input logic [2:0] unit,
                                        input logic [RN_W-1:0] rd2);
        writes_rd2 = (ty == TYPE_R) && (unit == UNIT_MULDIV) && (rd2 != '0);
    endfunction

endpackage

// File: rtl/issue_scheduler_scoreboard.sv
// 64-entry busy scoreboard: one two-register set port, WB_N clear ports and a
// four-read hazard lookup. r0 is never marked busy.
module issue_scheduler_scoreboard
    import issue_scheduler_pkg::*;
#(
    parameter int WB_N = WB_PORTS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_rd_i,
    input  logic [RN_W-1:0]        set_rd_rn_i,
    input  logic                   set_rd2_i,
    input  logic [RN_W-1:0]        set_rd2_rn_i,
    input  logic [WB_N-1:0]        clr_valid_i,
    input  logic [RN_W*WB_N-1:0]   clr_rn_i,
    input  logic [3:0]             look_en_i,
    input  logic [4*RN_W-1:0]      look_rn_i,
    output logic                   hazard_o,
    output logic [NUM_REGS-1:0]    busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [RN_W-1:0]     look_rn;

    always_comb begin
        set_mask = '0;
        if (set_rd_i) set_mask[set_rd_rn_i] = 1'b1;
        if (set_rd2_i) set_mask[set_rd2_rn_i] = 1'b1;
        set_mask[0] = 1'b0;

        clr_mask = '0;
        for (int i = 0; i < WB_N; i++) begin
            if (clr_valid_i[i]) clr_mask[clr_rn_i[i*RN_W +: RN_W]] = 1'b1;
        end

        // A new write to a register retiring this cycle must stay pending.
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        hazard_o = 1'b0;
        look_rn  = '0;
        for (int i = 0; i < 4; i++) begin
            look_rn = look_rn_i[i*RN_W +: RN_W];
            if (look_en_i[i] && (look_rn != '0) && busy_q[look_rn]) hazard_o = 1'b1;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/issue_scheduler.sv
// Issue controller between decode and the execution units: hazard hold,
// one-hot issue, in-flight counting and branch-redirect flush sequencing.
//
//  state | meaning
//  RUN   | normal issue; flush_req moves to FLUSH and blocks issue this cycle
//  FLUSH | cancel decode for one cycle, scoreboard kept for in-flight ops
//  DRAIN | no issue until every in-flight op has written back
module issue_scheduler
    import issue_scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic                     dec_type,
    input  logic [2:0]               dec_unit,
    input  logic [1:0]               dec_op,
    input  logic [RN_W-1:0]          dec_r1_rn,
    input  logic [RN_W-1:0]          dec_r2_rn,
    input  logic [RN_W-1:0]          dec_rd_rn,
    input  logic [RN_W-1:0]          dec_rd2_rn,
    input  logic [NUM_UNITS-1:0]     unit_ready,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [RN_W*WB_PORTS-1:0] wb_rn,
    input  logic                     flush_req,
    output logic                     stall,
    output logic                     cancel,
    output logic                     issue_valid,
    output logic [NUM_UNITS-1:0]     issue_unit,
    output logic [NUM_REGS-1:0]      busy_map
);

    sched_state_e     state_q;
    sched_state_e     state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   wb_cnt;
    logic             wr_rd;
    logic             wr_rd2;
    logic             hazard;
    logic             issue;
    logic [3:0]       look_en;

    assign wr_rd   = writes_rd(dec_type, dec_unit, dec_op, dec_rd_rn);
    assign wr_rd2  = writes_rd2(dec_type, dec_unit, dec_rd2_rn);
    assign look_en = {wr_rd2, wr_rd, dec_r2_rn != '0, dec_r1_rn != '0};

    issue_scheduler_scoreboard #(
        .WB_N (WB_PORTS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_rd_i     (issue & wr_rd),
        .set_rd_rn_i  (dec_rd_rn),
        .set_rd2_i    (issue & wr_rd2),
        .set_rd2_rn_i (dec_rd2_rn),
        .clr_valid_i  (wb_valid),
        .clr_rn_i     (wb_rn),
        .look_en_i    (look_en),
        .look_rn_i    ({dec_rd2_rn, dec_rd_rn, dec_r2_rn, dec_r1_rn}),
        .hazard_o     (hazard),
        .busy_o       (busy_map)
    );

    // flush_req gates issue directly so nothing slips out on the redirect cycle.
    assign issue = dec_valid & ~hazard & unit_ready[dec_unit] & (count_q < MAX_OUT)
                 & (state_q == ST_RUN) & ~flush_req;

    assign issue_valid = issue;
    assign issue_unit  = issue ? (NUM_UNITS'(1) << dec_unit) : '0;
    assign stall       = dec_valid & ~issue;

    always_comb begin
        wb_cnt = '0;
        for (int i = 0; i < WB_PORTS; i++) begin
            wb_cnt = wb_cnt + {{CNT_W{1'b0}}, wb_valid[i]};
        end
        count_d = CNT_W'({1'b0, count_q} + {{CNT_W{1'b0}}, issue} - wb_cnt);
    end

    always_comb begin
        state_d = state_q;
        cancel  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_req) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                cancel  = 1'b1;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A repeated redirect restarts the wait without another cancel.
                if (!flush_req && (count_q == '0)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    count_underflow: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, count_q} + {{CNT_W{1'b0}}, issue}) >= wb_cnt));

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed, table-driven bench for issue_scheduler with hand-computed expectations.
module tb_issue_scheduler;

    localparam logic R = 1'b0;
    localparam logic I = 1'b1;

    typedef struct {
        logic        rst;
        logic        dv;
        logic        ty;
        logic [2:0]  un;
        logic [1:0]  op;
        logic [5:0]  r1;
        logic [5:0]  r2;
        logic [5:0]  rd;
        logic [5:0]  rd2;
        logic [7:0]  rdy;
        logic [1:0]  wv;
        logic [5:0]  w0;
        logic [5:0]  w1;
        logic        fl;
        logic        e_stall;
        logic        e_cancel;
        logic        e_iv;
        logic [7:0]  e_unit;
        logic [63:0] e_busy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic        dec_type;
    logic [2:0]  dec_unit;
    logic [1:0]  dec_op;
    logic [5:0]  dec_r1_rn;
    logic [5:0]  dec_r2_rn;
    logic [5:0]  dec_rd_rn;
    logic [5:0]  dec_rd2_rn;
    logic [7:0]  unit_ready;
    logic [1:0]  wb_valid;
    logic [11:0] wb_rn;
    logic        flush_req;
    logic        stall;
    logic        cancel;
    logic        issue_valid;
    logic [7:0]  issue_unit;
    logic [63:0] busy_map;

    int checks;
    int failures;
    int vec_id;

    issue_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .dec_valid   (dec_valid),
        .dec_type    (dec_type),
        .dec_unit    (dec_unit),
        .dec_op      (dec_op),
        .dec_r1_rn   (dec_r1_rn),
        .dec_r2_rn   (dec_r2_rn),
        .dec_rd_rn   (dec_rd_rn),
        .dec_rd2_rn  (dec_rd2_rn),
        .unit_ready  (unit_ready),
        .wb_valid    (wb_valid),
        .wb_rn       (wb_rn),
        .flush_req   (flush_req),
        .stall       (stall),
        .cancel      (cancel),
        .issue_valid (issue_valid),
        .issue_unit  (issue_unit),
        .busy_map    (busy_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] b(input int n);
        b = 64'h1 << n;
    endfunction

    function automatic vec_t op_v(input logic ty, input logic [2:0] un, input logic [1:0] op,
                                  input logic [5:0] r1, input logic [5:0] r2,
                                  input logic [5:0] rd, input logic [5:0] rd2,
                                  input logic [1:0] wv, input logic [5:0] w0, input logic [5:0] w1,
                                  input logic fl, input logic es, input logic ec, input logic ei,
                                  input logic [7:0] eu, input logic [63:0] eb);
        vec_t v;
        v.rst = 1'b0; v.dv = 1'b1; v.ty = ty; v.un = un; v.op = op;
        v.r1 = r1; v.r2 = r2; v.rd = rd; v.rd2 = rd2; v.rdy = 8'hFF;
        v.wv = wv; v.w0 = w0; v.w1 = w1; v.fl = fl;
        v.e_stall = es; v.e_cancel = ec; v.e_iv = ei; v.e_unit = eu; v.e_busy = eb;
        return v;
    endfunction

    function automatic vec_t idle_v(input logic [1:0] wv, input logic [5:0] w0, input logic [5:0] w1,
                                    input logic fl, input logic ec, input logic [63:0] eb);
        vec_t v;
        v = op_v(R, 3'd0, 2'd0, 6'd0, 6'd0, 6'd0, 6'd0, wv, w0, w1, fl,
                 1'b0, ec, 1'b0, 8'h00, eb);
        v.dv = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, vec_id, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk);
        #1;
        rst        = v.rst;
        dec_valid  = v.dv;
        dec_type   = v.ty;
        dec_unit   = v.un;
        dec_op     = v.op;
        dec_r1_rn  = v.r1;
        dec_r2_rn  = v.r2;
        dec_rd_rn  = v.rd;
        dec_rd2_rn = v.rd2;
        unit_ready = v.rdy;
        wb_valid   = v.wv;
        wb_rn      = {v.w1, v.w0};
        flush_req  = v.fl;
        @(negedge clk);
        chk("stall",       {63'd0, stall},       {63'd0, v.e_stall});
        chk("cancel",      {63'd0, cancel},      {63'd0, v.e_cancel});
        chk("issue_valid", {63'd0, issue_valid}, {63'd0, v.e_iv});
        chk("issue_unit",  {56'd0, issue_unit},  {56'd0, v.e_unit});
        chk("busy_map",    busy_map,             v.e_busy);
        vec_id++;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        checks = 0; failures = 0; vec_id = 0;
        rst = 1'b1; dec_valid = 1'b0; dec_type = 1'b0; dec_unit = 3'd0; dec_op = 2'd0;
        dec_r1_rn = '0; dec_r2_rn = '0; dec_rd_rn = '0; dec_rd2_rn = '0;
        unit_ready = 8'hFF; wb_valid = '0; wb_rn = '0; flush_req = 1'b0;
        repeat (3) @(posedge clk);

        // reset state, then ADD r5 <- r1,r2 and a dependent reader of r5
        tbl.push_back(idle_v(2'b00, 0, 0, 0, 0, 64'd0));
        tbl.push_back(op_v(R, 0, 0, 1, 2, 5, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        tbl.push_back(op_v(R, 1, 0, 5, 0, 6, 0, 2'b00, 0, 0, 0, 1, 0, 0, 8'h00, b(5)));
        tbl.push_back(op_v(R, 1, 0, 5, 0, 6, 0, 2'b01, 5, 0, 0, 1, 0, 0, 8'h00, b(5)));
        tbl.push_back(op_v(R, 1, 0, 5, 0, 6, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h02, 64'd0));
        tbl.push_back(idle_v(2'b01, 6, 0, 0, 0, b(6)));
        // store reading busy r7 stalls, then issues without marking r7; BEQ sets nothing
        tbl.push_back(op_v(R, 0, 0, 0, 0, 7, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        tbl.push_back(op_v(I, 6, 0, 7, 0, 7, 0, 2'b00, 0, 0, 0, 1, 0, 0, 8'h00, b(7)));
        tbl.push_back(op_v(I, 6, 0, 7, 0, 7, 0, 2'b01, 7, 0, 0, 1, 0, 0, 8'h00, b(7)));
        tbl.push_back(op_v(I, 6, 0, 7, 0, 7, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h40, 64'd0));
        tbl.push_back(op_v(I, 7, 0, 1, 2, 8, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h80, 64'd0));
        tbl.push_back(idle_v(2'b11, 0, 0, 0, 0, 64'd0));
        // branch-and-link (op[1]=1) does write rd
        tbl.push_back(op_v(I, 7, 2'b10, 0, 0, 10, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h80, 64'd0));
        tbl.push_back(idle_v(2'b01, 10, 0, 0, 0, b(10)));
        // store (count filler), MUL r3,r4, WAW on r4 held until both ports clear
        tbl.push_back(op_v(I, 6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h40, 64'd0));
        tbl.push_back(op_v(R, 2, 0, 1, 2, 3, 4, 2'b00, 0, 0, 0, 0, 0, 1, 8'h04, 64'd0));
        tbl.push_back(op_v(R, 0, 0, 0, 0, 4, 0, 2'b11, 3, 4, 0, 1, 0, 0, 8'h00, b(3) | b(4)));
        tbl.push_back(op_v(R, 0, 0, 0, 0, 4, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        tbl.push_back(idle_v(2'b01, 4, 0, 0, 0, b(4)));
        // unit 3 not ready, then ready
        v = op_v(R, 3, 0, 0, 0, 12, 0, 2'b00, 0, 0, 0, 1, 0, 0, 8'h00, 64'd0);
        v.rdy = 8'hF7;
        tbl.push_back(v);
        tbl.push_back(op_v(R, 3, 0, 0, 0, 12, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h08, 64'd0));
        tbl.push_back(idle_v(2'b01, 12, 0, 0, 0, b(12)));
        // set and clear of r9 in the same cycle: the set wins
        tbl.push_back(op_v(I, 6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h40, 64'd0));
        tbl.push_back(op_v(R, 0, 0, 0, 0, 9, 0, 2'b01, 9, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        tbl.push_back(idle_v(2'b01, 9, 0, 0, 0, b(9)));
        tbl.push_back(idle_v(2'b00, 0, 0, 0, 0, 64'd0));
        // RAW on the second source
        tbl.push_back(op_v(R, 0, 0, 0, 0, 13, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        tbl.push_back(op_v(R, 1, 0, 0, 13, 14, 0, 2'b01, 13, 0, 0, 1, 0, 0, 8'h00, b(13)));
        tbl.push_back(op_v(R, 1, 0, 0, 13, 14, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h02, 64'd0));
        tbl.push_back(idle_v(2'b01, 14, 0, 0, 0, b(14)));
        tbl.push_back(idle_v(2'b00, 0, 0, 0, 0, 64'd0));

        foreach (tbl[k]) run_vec(tbl[k]);

        // flush with three in flight; repeated flush in FLUSH and in DRAIN
        run_vec(op_v(R, 0, 0, 0, 0, 20, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        run_vec(op_v(R, 0, 0, 0, 0, 21, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, b(20)));
        run_vec(op_v(R, 0, 0, 0, 0, 22, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, b(20) | b(21)));
        run_vec(op_v(R, 0, 0, 0, 0, 23, 0, 2'b00, 0, 0, 1, 1, 0, 0, 8'h00, b(20) | b(21) | b(22)));
        run_vec(op_v(R, 0, 0, 0, 0, 23, 0, 2'b00, 0, 0, 1, 1, 1, 0, 8'h00, b(20) | b(21) | b(22)));
        run_vec(op_v(R, 0, 0, 0, 0, 23, 0, 2'b01, 20, 0, 0, 1, 0, 0, 8'h00, b(20) | b(21) | b(22)));
        run_vec(op_v(R, 0, 0, 0, 0, 23, 0, 2'b01, 21, 0, 0, 1, 0, 0, 8'h00, b(21) | b(22)));
        run_vec(op_v(R, 0, 0, 0, 0, 23, 0, 2'b01, 22, 0, 0, 1, 0, 0, 8'h00, b(22)));
        run_vec(op_v(R, 0, 0, 0, 0, 23, 0, 2'b00, 0, 0, 1, 1, 0, 0, 8'h00, 64'd0));
        run_vec(op_v(R, 0, 0, 0, 0, 23, 0, 2'b00, 0, 0, 0, 1, 0, 0, 8'h00, 64'd0));
        run_vec(op_v(R, 0, 0, 0, 0, 23, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        run_vec(idle_v(2'b01, 23, 0, 0, 0, b(23)));

        // fifteen in flight, the sixteenth stalls until one retires
        for (int k = 0; k < 15; k++)
            run_vec(op_v(I, 6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h40, 64'd0));
        run_vec(op_v(I, 6, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 8'h00, 64'd0));
        run_vec(op_v(I, 6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h40, 64'd0));
        for (int k = 0; k < 7; k++)
            run_vec(idle_v(2'b11, 0, 0, 0, 0, 64'd0));
        run_vec(idle_v(2'b01, 0, 0, 0, 0, 64'd0));
        run_vec(op_v(R, 0, 0, 0, 0, 24, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        run_vec(idle_v(2'b01, 24, 0, 0, 0, b(24)));

        // reset asserted mid-drain returns to RUN with an empty scoreboard
        run_vec(op_v(R, 0, 0, 0, 0, 30, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        run_vec(op_v(R, 0, 0, 0, 0, 31, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, b(30)));
        run_vec(idle_v(2'b00, 0, 0, 1, 0, b(30) | b(31)));
        run_vec(idle_v(2'b00, 0, 0, 0, 1, b(30) | b(31)));
        v = idle_v(2'b00, 0, 0, 0, 0, b(30) | b(31));
        v.rst = 1'b1;
        run_vec(v);
        run_vec(op_v(R, 0, 0, 0, 0, 30, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'h01, 64'd0));
        run_vec(idle_v(2'b01, 30, 0, 0, 0, b(30)));
        run_vec(idle_v(2'b00, 0, 0, 0, 0, 64'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
